// File: rtl/shift_reg_sipo_rx_pkg.sv
// Constants and helpers shared by the serial receiver and its shift core.
package shift_reg_sipo_rx_pkg;

  // Word length shared with the 4-bit PISO transmitter on the other end of the link.
  localparam int DEFAULT_WIDTH = 4;

  // Ceiling log2, used to size the bit counter from the word length.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_reg_sipo_rx_sipo_shift_core.sv
// Shift register plus bit counter. It assembles MSB-first words from qualified
// serial bits and strobes word_done on the edge that carries the last bit.
module sipo_shift_core
  import shift_reg_sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             si,
  input  logic             sh,
  input  logic             sync,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [WIDTH-1:0] sreg_r;
  logic [CNT_W-1:0] cnt_r;

  // The word presented on a completing edge includes the bit being sampled now.
  assign word      = {sreg_r[WIDTH-2:0], si};
  // A realign on the final-bit edge suppresses completion.
  assign word_done = sh & ~sync & (cnt_r == LAST_IDX);
  assign busy      = (cnt_r != CNT_ZERO);

  // Shift and count on qualified edges; realign restarts the frame, keeping SI if it is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_r <= {WIDTH{1'b0}};
      cnt_r  <= CNT_ZERO;
    end else if (sync) begin
      sreg_r <= sh ? {{(WIDTH-1){1'b0}}, si} : {WIDTH{1'b0}};
      cnt_r  <= sh ? CNT_ONE : CNT_ZERO;
    end else if (sh) begin
      sreg_r <= word;
      cnt_r  <= (cnt_r == LAST_IDX) ? CNT_ZERO : cnt_r + CNT_ONE;
    end else begin
      sreg_r <= sreg_r;
      cnt_r  <= cnt_r;
    end
  end

endmodule

// File: rtl/shift_reg_sipo_rx.sv
// Serial-in parallel-out receiver: assembles words from the serial link and
// hands them downstream through a single holding register with VALID/RDY.
// Words completing while the holder is occupied and not draining are dropped
// and recorded in a sticky overflow flag.
module shift_reg_sipo_rx
  import shift_reg_sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             SI,
  input  logic             SH,
  input  logic             SYNC,
  input  logic             RDY,
  input  logic             OVF_CLR,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             OVF,
  output logic             BUSY
);

  logic [WIDTH-1:0] word_s;
  logic             word_done_s;
  logic             busy_s;
  logic             load_s;
  logic             drop_s;
  logic [WIDTH-1:0] q_r;
  logic             valid_r;
  logic             ovf_r;

  sipo_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (CLK),
    .rst_n    (nRST),
    .si       (SI),
    .sh       (SH),
    .sync     (SYNC),
    .word     (word_s),
    .word_done(word_done_s),
    .busy     (busy_s)
  );

  // The holder is free when empty or being drained on this same edge.
  assign load_s = word_done_s & (~valid_r | RDY);
  assign drop_s = word_done_s & valid_r & ~RDY;

  // Output holding register and handshake state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q_r     <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else if (load_s) begin
      q_r     <= word_s;
      valid_r <= 1'b1;
    end else if (valid_r && RDY) begin
      q_r     <= q_r;
      valid_r <= 1'b0;
    end else begin
      q_r     <= q_r;
      valid_r <= valid_r;
    end
  end

  // Sticky overflow; a drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (OVF_CLR) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign Q     = q_r;
  assign VALID = valid_r;
  assign OVF   = ovf_r;
  assign BUSY  = busy_s;

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// Self-checking bench for shift_reg_sipo_rx: directed scenarios plus randomized
// traffic, all compared against a frame-level reference model every cycle.
module tb_shift_reg_sipo_rx;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         SI, SH, SYNC, RDY, OVF_CLR;
  logic [W-1:0] Q;
  logic         VALID, OVF, BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: bits of the frame in progress and the output holder.
  int m_cnt;
  int m_acc;
  int m_q;
  bit m_valid;
  bit m_ovf;

  shift_reg_sipo_rx #(.WIDTH(W)) dut (
    .CLK(CLK), .nRST(nRST), .SI(SI), .SH(SH), .SYNC(SYNC), .RDY(RDY),
    .OVF_CLR(OVF_CLR), .Q(Q), .VALID(VALID), .OVF(OVF), .BUSY(BUSY)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_acc = 0; m_q = 0; m_valid = 1'b0; m_ovf = 1'b0;
  endtask

  // One rising edge of the receiver, described at frame level.
  task automatic model_edge(input bit si, input bit sh, input bit sync, input bit rdy, input bit clr);
    bit done;
    bit dropped;
    int w;
    done = 1'b0; dropped = 1'b0; w = 0;
    if (sync) begin
      m_cnt = 0; m_acc = 0;
    end
    if (sh) begin
      m_acc = (m_acc * 2 + int'(si)) % (1 << W);
      m_cnt = m_cnt + 1;
      if (m_cnt == W) begin
        done = 1'b1; w = m_acc; m_cnt = 0; m_acc = 0;
      end
    end
    if (m_valid && rdy) m_valid = 1'b0;
    if (done) begin
      if (!m_valid) begin
        m_q = w; m_valid = 1'b1;
      end else begin
        dropped = 1'b1;
      end
    end
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic compare_all(input string ctx);
    check_eq({ctx, "_q"},     16'(Q),     16'(m_q));
    check_eq({ctx, "_valid"}, 16'(VALID), 16'(m_valid));
    check_eq({ctx, "_ovf"},   16'(OVF),   16'(m_ovf));
    check_eq({ctx, "_busy"},  16'(BUSY),  16'(m_cnt != 0));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check at the falling edge.
  task automatic cycle(input bit si, input bit sh, input bit sync, input bit rdy, input bit clr);
    SI = si; SH = sh; SYNC = sync; RDY = rdy; OVF_CLR = clr;
    @(posedge CLK);
    model_edge(si, sh, sync, rdy, clr);
    @(negedge CLK);
    compare_all("model");
  endtask

  // Send a word MSB first with 'gap' idle cycles between bits; rdy_last applies to the final bit.
  task automatic send_word(input logic [W-1:0] w, input int gap, input bit rdy, input bit rdy_last);
    logic [W-1:0] wv;
    wv = w;
    for (int i = W - 1; i >= 0; i--) begin
      cycle(wv[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy, 1'b0);
      if (i > 0) begin
        for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b0, rdy, 1'b0);
      end
    end
  endtask

  // Asynchronous reset asserted between edges and released on a falling edge.
  task automatic async_reset();
    #2 nRST = 1'b0;
    SH = 1'b0; SYNC = 1'b0; RDY = 1'b0; OVF_CLR = 1'b0;
    #1;
    model_reset();
    check_eq("rst_q",     16'(Q),     16'd0);
    check_eq("rst_valid", 16'(VALID), 16'd0);
    check_eq("rst_ovf",   16'(OVF),   16'd0);
    check_eq("rst_busy",  16'(BUSY),  16'd0);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; SI = 1'b0; SH = 1'b0; SYNC = 1'b0; RDY = 1'b0; OVF_CLR = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    compare_all("init");

    // Idle: SH low leaves everything untouched regardless of SI.
    for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("idle_busy", 16'(BUSY), 16'd0);

    // Basic word with downstream ready.
    send_word(4'b1011, 0, 1'b1, 1'b1);
    check_eq("basic_q",     16'(Q),     16'(4'b1011));
    check_eq("basic_valid", 16'(VALID), 16'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("basic_drain", 16'(VALID), 16'd0);

    // Gapped bits followed by a back-to-back word.
    send_word(4'b1100, 2, 1'b1, 1'b1);
    check_eq("gap_q", 16'(Q), 16'(4'b1100));
    send_word(4'b0110, 0, 1'b1, 1'b1);
    check_eq("b2b_q",   16'(Q),   16'(4'b0110));
    check_eq("b2b_ovf", 16'(OVF), 16'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure and overflow.
    send_word(4'b1001, 0, 1'b0, 1'b0);
    send_word(4'b0111, 0, 1'b0, 1'b0);
    check_eq("ovf_q",     16'(Q),     16'(4'b1001));
    check_eq("ovf_valid", 16'(VALID), 16'd1);
    check_eq("ovf_set",   16'(OVF),   16'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("ovf_drain", 16'(VALID), 16'd0);
    check_eq("ovf_held",  16'(OVF),   16'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("ovf_clr", 16'(OVF), 16'd0);

    // Transfer and completion on the same edge.
    send_word(4'b0001, 0, 1'b0, 1'b0);
    send_word(4'b1110, 0, 1'b0, 1'b1);
    check_eq("simul_q",     16'(Q),     16'(4'b1110));
    check_eq("simul_valid", 16'(VALID), 16'd1);
    check_eq("simul_ovf",   16'(OVF),   16'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // SYNC realign keeps the concurrent bit as the new first bit.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("sync_q",    16'(Q),     16'(4'b0101));
    check_eq("sync_busy", 16'(BUSY),  16'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // SYNC on the completing edge suppresses the word.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("sync_last_valid", 16'(VALID), 16'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of activity.
    send_word(4'b1111, 0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    async_reset();
    compare_all("post_rst");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        cycle(1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 15) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_sipo_rx.md
Name: shift_reg_sipo_rx

Overview:
Serial-in parallel-out receiver. It is the receiving end of the 4-bit PISO serial link, which sends MSB first and shifts while SnL=1. The block samples SI on qualified clock edges, assembles WIDTH-bit words, and presents each word on Q with a VALID/RDY handshake. It also includes one output holding register, frame realignment (SYNC) and a sticky overflow flag. It sits between the serial link and the character-matching logic of the string recognizer.

Parameters:
WIDTH, 4, word length in bits; legal range 2..16; 4 matches the PISO transmitter.
CNT_W, derived as clog2(WIDTH), width of the bit counter; not overridable.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
nRST  input  1  asynchronous active-low reset.
SI  input  1  serial data from the transmitter's so.
SH  input  1  shift qualifier; SI is a valid bit on this edge when 1 (driven from transmitter SnL phase).
SYNC  input  1  synchronous frame realign; discards partial word.
RDY  input  1  downstream accepts Q this cycle when VALID=1.
OVF_CLR  input  1  synchronous clear of OVF.
Q  output  WIDTH  received word, MSB = first bit received.
VALID  output  1  Q holds an unconsumed word.
OVF  output  1  sticky: a completed word was dropped.
BUSY  output  1  partial word in progress (bit count != 0).

Behaviour:
- Reset (nRST=0, async): shift register, bit counter, Q, VALID and OVF all go to 0 immediately; BUSY=0. On nRST deassertion the block accepts bits on the next qualified edge.
- Shift: on an edge with SH=1, sreg <= {sreg[WIDTH-2:0], SI}, then cnt <= cnt+1. MSB first, so the first bit lands at Q[WIDTH-1].
- Word completion: on an edge with SH=1 and cnt==WIDTH-1, the word is {sreg[WIDTH-2:0], SI}, and cnt wraps to 0.
  - If the output is free (VALID=0, or VALID=1 and RDY=1 on the same edge): Q <= word and VALID <= 1. VALID is therefore visible the cycle after the last bit's edge (latency 1 from the last sampled bit).
  - Otherwise: the word is dropped, Q is unchanged, and OVF <= 1.
- Handshake: a transfer occurs on an edge where VALID=1 and RDY=1. VALID then drops to 0 unless a new word completes on the same edge, in which case VALID stays 1 and Q takes the new word. Q is stable while VALID=1 and RDY=0. RDY while VALID=0 has no effect.
- SH=0: no shift and no count change, so gaps of any length between bits are tolerated.
- SYNC=1: cnt <= 0 and the partial word is discarded.
  - If SH=1 on the same edge, SI is taken as bit 0 of the new word (cnt <= 1).
  - SYNC never affects Q, VALID or OVF.
  - SYNC on the edge that would complete a word wins, so no word is produced.
- OVF: set as above and held until OVF_CLR=1 or reset. If a drop and OVF_CLR coincide, set wins (OVF stays 1).
- BUSY = (cnt != 0), combinational from the registered counter.
- No combinational path from SI or SH to any output; Q, VALID and OVF are registers.

Decomposition:
- Shared constants file: default WIDTH (4, common with the transmitter) and a clog2 function for CNT_W.
- One natural sub-module: sipo_shift_core, containing the WIDTH-bit shift register plus bit counter, with SYNC/SH inputs and a word_done strobe output. The top level holds the output register, handshake and OVF logic.

Test Plan:
- Reset/idle: nRST=0 mid-run, then release → Q=0, VALID=0, OVF=0, BUSY=0. With SH=0 for 10 cycles, nothing changes.
- Basic word: with RDY=1, send SI=1,0,1,1 on 4 consecutive SH=1 edges → VALID=1 for one cycle, Q=4'b1011, one cycle after the 4th edge. BUSY=1 after edges 1-3.
- Gapped bits plus back-to-back words: send 1,1,0,0 with SH=0 gaps of 2 cycles between bits, then immediately 0,1,1,0 while RDY=1 → Q=4'b1100 then Q=4'b0110, with no OVF.
- Backpressure/overflow: RDY=0, send 4'b1001 then 4'b0111 → Q stays 4'b1001 with VALID=1 and OVF=1 after the 8th bit. Then RDY=1 for one cycle → VALID=0. OVF_CLR=1 → OVF=0.
- Simultaneous transfer and completion: hold Q=4'b0001 with VALID=1. Assert RDY=1 on the same edge as the last bit of 4'b1110 → VALID stays 1, Q=4'b1110, OVF=0.
- SYNC realign: send bits 1,1 then SYNC=1 with SH=1 and SI=0, then 1,0,1 → Q=4'b0101, BUSY=0 afterward. SYNC asserted on the 4th-bit edge instead → no VALID.
